// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetric function evaluator.
package autosym_pkg;

    // Operating states of the evaluator control FSM.
    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Address width for n entries, never narrower than one bit so that
    // single-row configurations still have a legal port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/autosym_eval_pipe_gf2_matvec.sv
// Combinational GF(2) projection r = A*x: each reduced bit is the parity of
// the input bits selected by its matrix row.
module gf2_matvec
    import autosym_pkg::*;
#(
    parameter int N_IN = 11,
    parameter int K    = 8
) (
    input  logic [K-1:0][N_IN-1:0] mat,
    input  logic [N_IN-1:0]        x,
    output logic [K-1:0]           r
);

    // AND each row with x, then XOR-reduce to a single reduced bit.
    always_comb begin
        r = '0;
        for (int i = 0; i < K; i++) begin
            r[i] = ^(mat[i] & x);
        end
    end

endmodule

// File: rtl/autosym_eval_pipe.sv
// Streaming evaluator f(x) = f_r(A*x): a programmable XOR projection followed
// by a programmable truth-table lookup, two register stages, valid/ready
// handshake, and a drain-before-reconfigure control FSM.
module autosym_eval_pipe
    import autosym_pkg::*;
#(
    parameter int N_IN  = 11,
    parameter int K     = 8,
    parameter int N_OUT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT-1:0]         out_y,
    input  logic                     cfg_req,
    output logic                     cfg_mode,
    input  logic                     mat_we,
    input  logic [clog2_min1(K)-1:0] mat_addr,
    input  logic [N_IN-1:0]          mat_data,
    input  logic                     tt_we,
    input  logic [K-1:0]             tt_addr,
    input  logic [N_OUT-1:0]         tt_data,
    input  logic                     cfg_done
);

    localparam int AW       = clog2_min1(K);
    localparam int TT_DEPTH = 1 << K;

    state_t                 state;
    state_t                 state_nxt;

    logic [K-1:0][N_IN-1:0] mat;
    logic [N_OUT-1:0]       tt [TT_DEPTH];

    logic [K-1:0]           r_p0;
    logic [K-1:0]           r_p1;
    logic                   vld_p1;
    logic [N_OUT-1:0]       y_p2;
    logic                   vld_p2;

    logic                   advance;
    logic                   accept;
    logic                   cfg_wr_ok;
    logic                   pipe_empty;

    // Whole pipeline moves together unless the output register is held.
    assign advance    = !vld_p2 || out_ready;
    assign in_ready   = (state == ST_RUN) && advance;
    assign accept     = in_valid && in_ready;
    assign cfg_wr_ok  = (state == ST_CFG);
    assign pipe_empty = !vld_p1 && !vld_p2;

    assign out_valid  = vld_p2;
    assign out_y      = y_p2;

    // Next-state logic: CFG -> RUN on cfg_done, RUN -> DRAIN on cfg_req,
    // DRAIN -> CFG once nothing is left in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CFG:   if (cfg_done)   state_nxt = ST_RUN;
            ST_RUN:   if (cfg_req)    state_nxt = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_nxt = ST_CFG;
            default:                  state_nxt = ST_CFG;
        endcase
    end

    // State register; cfg_mode is registered from the next state so it
    // always equals (state == CFG) without a decode after the flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CFG;
            cfg_mode <= 1'b1;
        end else begin
            state    <= state_nxt;
            cfg_mode <= (state_nxt == ST_CFG);
        end
    end

    // Projection matrix: identity on the low K bits after reset; writes only
    // in CFG, and row addresses beyond K-1 match no row and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                mat[i] <= N_IN'(1) << i;
            end
        end else if (mat_we && cfg_wr_ok) begin
            for (int i = 0; i < K; i++) begin
                if (mat_addr == AW'(i)) begin
                    mat[i] <= mat_data;
                end
            end
        end
    end

    // Truth table: cleared on reset, written only in CFG (pipeline empty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < TT_DEPTH; e++) begin
                tt[e] <= '0;
            end
        end else if (tt_we && cfg_wr_ok) begin
            tt[tt_addr] <= tt_data;
        end
    end

    gf2_matvec #(
        .N_IN (N_IN),
        .K    (K)
    ) u_matvec (
        .mat (mat),
        .x   (in_x),
        .r   (r_p0)
    );

    // Stage 1: capture the reduced vector of the accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            r_p1   <= '0;
        end else if (advance) begin
            vld_p1 <= accept;
            if (accept) begin
                r_p1 <= r_p0;
            end
        end
    end

    // Stage 2: output register holding TT[r]; frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            y_p2   <= '0;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                y_p2 <= tt[r_p1];
            end
        end
    end

endmodule

// File: tb/tb_autosym_eval_pipe.sv
// Self-checking bench for autosym_eval_pipe: a default instance (K=8, N_OUT=1)
// and a K=4, N_OUT=3 instance, checked against a parity/lookup model.
module tb_autosym_eval_pipe;
    import autosym_pkg::*;

    localparam int N_IN = 11;
    localparam int K1   = 8;
    localparam int O1   = 1;
    localparam int K3   = 4;
    localparam int O3   = 3;
    localparam int AW1  = clog2_min1(K1);
    localparam int AW3  = clog2_min1(K3);

    logic clk = 1'b0;
    logic rst;

    logic            in_valid1, in_ready1, out_valid1, out_ready1;
    logic            cfg_req1, cfg_mode1, mat_we1, tt_we1, cfg_done1;
    logic [N_IN-1:0] in_x1, mat_data1;
    logic [O1-1:0]   out_y1, tt_data1;
    logic [AW1-1:0]  mat_addr1;
    logic [K1-1:0]   tt_addr1;

    logic            in_valid3, in_ready3, out_valid3, out_ready3;
    logic            cfg_req3, cfg_mode3, mat_we3, tt_we3, cfg_done3;
    logic [N_IN-1:0] in_x3, mat_data3;
    logic [O3-1:0]   out_y3, tt_data3;
    logic [AW3-1:0]  mat_addr3;
    logic [K3-1:0]   tt_addr3;

    int checks = 0;
    int errors = 0;

    logic [N_IN-1:0] a1_m [K1];
    logic [O1-1:0]   tt1_m [1 << K1];
    logic [N_IN-1:0] a3_m [K3];
    logic [O3-1:0]   tt3_m [1 << K3];

    logic [O1-1:0] q1 [$];
    logic [O3-1:0] q3 [$];
    int pops1 = 0, sent1 = 0, pops3 = 0;
    bit acc1 = 0, acc3 = 0, stall_prev1 = 0;
    logic [O1-1:0] y_prev1 = '0;

    always #5 clk = ~clk;

    autosym_eval_pipe #(.N_IN(N_IN), .K(K1), .N_OUT(O1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_x(in_x1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_y(out_y1),
        .cfg_req(cfg_req1), .cfg_mode(cfg_mode1),
        .mat_we(mat_we1), .mat_addr(mat_addr1), .mat_data(mat_data1),
        .tt_we(tt_we1), .tt_addr(tt_addr1), .tt_data(tt_data1),
        .cfg_done(cfg_done1)
    );

    autosym_eval_pipe #(.N_IN(N_IN), .K(K3), .N_OUT(O3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_x(in_x3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3),
        .cfg_req(cfg_req3), .cfg_mode(cfg_mode3),
        .mat_we(mat_we3), .mat_addr(mat_addr3), .mat_data(mat_data3),
        .tt_we(tt_we3), .tt_addr(tt_addr3), .tt_data(tt_data3),
        .cfg_done(cfg_done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // f(x): reduced code bit i is the parity of the input bits picked by row i.
    function automatic logic [O1-1:0] model1(input logic [N_IN-1:0] x);
        int code = 0;
        for (int i = 0; i < K1; i++)
            if ($countones(a1_m[i] & x) % 2 == 1) code += (1 << i);
        return tt1_m[code];
    endfunction

    function automatic logic [O3-1:0] model3(input logic [N_IN-1:0] x);
        int code = 0;
        for (int i = 0; i < K3; i++)
            if ($countones(a3_m[i] & x) % 2 == 1) code += (1 << i);
        return tt3_m[code];
    endfunction

    task automatic reset_models();
        for (int i = 0; i < K1; i++) a1_m[i] = N_IN'(1) << i;
        for (int e = 0; e < (1 << K1); e++) tt1_m[e] = '0;
        for (int i = 0; i < K3; i++) a3_m[i] = N_IN'(1) << i;
        for (int e = 0; e < (1 << K3); e++) tt3_m[e] = '0;
    endtask

    // One clock: observe handshakes at the falling edge, return just after
    // the next rising edge so the caller can drive fresh inputs.
    task automatic cycle();
        @(negedge clk);
        acc1 = in_valid1 && in_ready1;
        acc3 = in_valid3 && in_ready3;
        if (stall_prev1) begin
            chk("hold_valid", out_valid1, 1);
            chk("hold_y", out_y1, y_prev1);
        end
        if (out_valid1 && !out_ready1) chk("stall_in_ready", in_ready1, 0);
        if (out_valid1 && out_ready1) begin
            chk("out1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) chk("out_y1", out_y1, q1.pop_front());
            pops1++;
        end
        if (acc1) begin
            q1.push_back(model1(in_x1));
            sent1++;
        end
        stall_prev1 = out_valid1 && !out_ready1;
        y_prev1 = out_y1;
        if (out_valid3 && out_ready3) begin
            chk("out3_expected", q3.size() != 0, 1);
            if (q3.size() != 0) chk("out_y3", out_y3, q3.pop_front());
            pops3++;
        end
        if (acc3) q3.push_back(model3(in_x3));
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [N_IN-1:0] x);
        bit got = 0;
        in_valid1 = 1'b1;
        in_x1 = x;
        for (int n = 0; n < 40 && !got; n++) begin
            cycle();
            got = acc1;
        end
        in_valid1 = 1'b0;
        chk("send1_accepted", got, 1);
    endtask

    task automatic drain1();
        for (int n = 0; n < 40 && (q1.size() != 0 || out_valid1); n++) cycle();
        chk("drain1_done", (q1.size() == 0) && !out_valid1, 1);
    endtask

    task automatic wait_cfg1();
        for (int n = 0; n < 40 && cfg_mode1 !== 1'b1; n++) cycle();
        chk("cfg_mode_entered", cfg_mode1, 1);
    endtask

    task automatic enter_cfg1();
        cfg_req1 = 1'b1;
        cycle();
        cfg_req1 = 1'b0;
        wait_cfg1();
    endtask

    task automatic pulse_done1();
        cfg_done1 = 1'b1;
        cycle();
        cfg_done1 = 1'b0;
        chk("cfg_mode_run", cfg_mode1, 0);
    endtask

    task automatic mat_write1(input int addr, input logic [N_IN-1:0] data, input bit eff);
        mat_we1 = 1'b1; mat_addr1 = AW1'(addr); mat_data1 = data;
        cycle();
        mat_we1 = 1'b0;
        if (eff) a1_m[addr] = data;
    endtask

    task automatic tt_write1(input int addr, input logic [O1-1:0] data, input bit eff);
        tt_we1 = 1'b1; tt_addr1 = K1'(addr); tt_data1 = data;
        cycle();
        tt_we1 = 1'b0;
        if (eff) tt1_m[addr] = data;
    endtask

    initial begin
        logic [N_IN-1:0] par_vec [4];
        logic [N_IN-1:0] x;
        int pc, sc;

        rst = 1'b1;
        in_valid1 = 0; in_x1 = '0; out_ready1 = 1; cfg_req1 = 0; cfg_done1 = 0;
        mat_we1 = 0; mat_addr1 = '0; mat_data1 = '0; tt_we1 = 0; tt_addr1 = '0; tt_data1 = '0;
        in_valid3 = 0; in_x3 = '0; out_ready3 = 1; cfg_req3 = 0; cfg_done3 = 0;
        mat_we3 = 0; mat_addr3 = '0; mat_data3 = '0; tt_we3 = 0; tt_addr3 = '0; tt_data3 = '0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset defaults
        chk("rst_cfg_mode", cfg_mode1, 1);
        chk("rst_in_ready", in_ready1, 0);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_out_y", out_y1, 0);
        chk("rst_cfg_mode3", cfg_mode3, 1);

        // TT write in RUN is ignored; identity A
        pulse_done1();
        tt_write1(5, 1'b1, 0);
        send1(11'h005);
        drain1();
        enter_cfg1();
        tt_write1(5, 1'b1, 1);
        pulse_done1();
        in_valid1 = 1'b1;
        in_x1 = 11'h105;
        cycle();
        chk("lat_accept", acc1, 1);
        in_valid1 = 1'b0;
        chk("lat_s1_only", out_valid1, 0);
        cycle();
        chk("lat_out_valid", out_valid1, 1);
        chk("lat_out_y", out_y1, 1);
        drain1();

        // Parity function on row 0, back-to-back stream
        enter_cfg1();
        mat_write1(0, 11'h7FF, 1);
        for (int i = 1; i < K1; i++) mat_write1(i, '0, 1);
        tt_write1(0, 1'b0, 1);
        tt_write1(1, 1'b1, 1);
        pulse_done1();
        par_vec[0] = 11'h001; par_vec[1] = 11'h003; par_vec[2] = 11'h7FF; par_vec[3] = 11'h000;
        pc = pops1;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1'b1;
            in_x1 = par_vec[i];
            cycle();
            chk("b2b_accept", acc1, 1);
        end
        in_valid1 = 1'b0;
        cycle();
        cycle();
        chk("b2b_pops", pops1 - pc, 4);

        // Backpressure: 5-cycle hold mid-stream
        sc = sent1; pc = pops1;
        x = N_IN'($urandom);
        in_valid1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            out_ready1 = !(c >= 8 && c < 13);
            in_x1 = x;
            cycle();
            if (acc1) x = N_IN'($urandom);
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        drain1();
        chk("bp_count", pops1 - pc, sent1 - sc);

        // Random valid/ready traffic
        sc = sent1; pc = pops1;
        acc1 = 0;
        for (int c = 0; c < 80; c++) begin
            if (!in_valid1 || acc1) begin
                in_valid1 = 1'($urandom_range(0, 1));
                in_x1 = N_IN'($urandom);
            end
            out_ready1 = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        drain1();
        chk("rand_count", pops1 - pc, sent1 - sc);

        // Reconfigure with two vectors in flight
        pc = pops1;
        in_valid1 = 1'b1;
        in_x1 = 11'h001;
        cycle();
        chk("rc_first_accept", acc1, 1);
        in_x1 = 11'h7FF;
        cfg_req1 = 1'b1;
        cycle();
        chk("rc_req_cycle_accept", acc1, 1);
        cfg_req1 = 1'b0;
        in_x1 = 11'h003;
        chk("rc_drain_in_ready", in_ready1, 0);
        tt_write1(1, 1'b0, 0);
        chk("rc_drain_cfg_mode", cfg_mode1, 0);
        in_valid1 = 1'b0;
        wait_cfg1();
        chk("rc_queue_empty", q1.size(), 0);
        chk("rc_emitted", pops1 - pc, 2);
        pulse_done1();
        send1(11'h001);
        drain1();

        // Asynchronous reset mid-stream
        in_valid1 = 1'b1;
        in_x1 = N_IN'($urandom);
        cycle();
        in_x1 = N_IN'($urandom);
        cycle();
        in_valid1 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid1, 0);
        chk("arst_cfg_mode", cfg_mode1, 1);
        chk("arst_in_ready", in_ready1, 0);
        chk("arst_out_y", out_y1, 0);
        q1.delete();
        stall_prev1 = 0;
        reset_models();
        cycle();
        rst = 1'b0;
        tt_write1(6, 1'b1, 1);
        pulse_done1();
        send1(11'h106);
        send1(11'h007);
        drain1();

        // K=4, N_OUT=3 instance: three tables, sweep all 16 codes
        for (int c = 0; c < 16; c++) begin
            tt_we3 = 1'b1;
            tt_addr3 = K3'(c);
            tt_data3 = O3'($urandom);
            cycle();
            tt3_m[c] = tt_data3;
        end
        tt_we3 = 1'b0;
        cfg_done3 = 1'b1;
        cycle();
        cfg_done3 = 1'b0;
        chk("k4_cfg_mode_run", cfg_mode3, 0);
        pc = pops3;
        in_valid3 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_x3 = (N_IN'($urandom) & 11'h7F0) | N_IN'(c);
            cycle();
            chk("k4_accept", acc3, 1);
        end
        in_valid3 = 1'b0;
        for (int n = 0; n < 40 && (q3.size() != 0 || out_valid3); n++) cycle();
        chk("k4_drained", q3.size(), 0);
        chk("k4_pops", pops3 - pc, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
